// File: rtl/commit_flush_sequencer_pkg.sv
// Shared pipeline definitions: commit event kinds and sequencer FSM states.
package pipeline_defines;

  typedef enum logic [2:0] {
    CK_NONE    = 3'd0,
    CK_EXCP    = 3'd1,
    CK_ERTN    = 3'd2,
    CK_REFETCH = 3'd3,
    CK_IDLE    = 3'd4
  } commit_kind_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/commit_flush_sequencer.sv
// Serialises commit-time events (exception, ertn, refetch, idle) from two commit
// slots into a fixed-length pipeline flush followed by a single fetch redirect.
module commit_flush_sequencer
  import pipeline_defines::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot0_valid,
  input  commit_kind_e      slot0_kind,
  input  logic [ADDR_W-1:0] slot0_pc,
  input  logic              slot0_tlbr,
  input  logic              slot1_valid,
  input  commit_kind_e      slot1_kind,
  input  logic [ADDR_W-1:0] slot1_pc,
  input  logic              slot1_tlbr,
  input  logic [ADDR_W-1:0] excp_entry_i,
  input  logic [ADDR_W-1:0] tlbr_entry_i,
  input  logic [ADDR_W-1:0] era_i,
  input  logic              int_pending_i,
  output logic              squash_slot1_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              csr_excp_we_o,
  output logic              csr_ertn_we_o,
  output logic              idle_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("commit_flush_sequencer: FLUSH_CYCLES must be >= 1");
  end

  seq_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  commit_kind_e      kind_q, kind_n;
  logic [ADDR_W-1:0] target_q, target_n;
  logic              flush_n, redirect_n, excp_we_n, ertn_we_n;

  logic              evt_valid;
  commit_kind_e      evt_kind;
  logic [ADDR_W-1:0] evt_pc;
  logic              evt_tlbr;
  logic [ADDR_W-1:0] evt_target;
  logic              accept;
  logic              flush_last;

  // Slot0 is older, so it wins whenever it carries an event.
  always_comb begin
    evt_valid = 1'b0;
    evt_kind  = CK_NONE;
    evt_pc    = '0;
    evt_tlbr  = 1'b0;
    if (slot0_valid && slot0_kind != CK_NONE) begin
      evt_valid = 1'b1;
      evt_kind  = slot0_kind;
      evt_pc    = slot0_pc;
      evt_tlbr  = slot0_tlbr;
    end else if (slot1_valid && slot1_kind != CK_NONE) begin
      evt_valid = 1'b1;
      evt_kind  = slot1_kind;
      evt_pc    = slot1_pc;
      evt_tlbr  = slot1_tlbr;
    end
  end

  always_comb begin
    evt_target = evt_pc + ADDR_W'(4);
    case (evt_kind)
      CK_EXCP: evt_target = evt_tlbr ? tlbr_entry_i : excp_entry_i;
      CK_ERTN: evt_target = era_i;
      default: evt_target = evt_pc + ADDR_W'(4);
    endcase
  end

  assign accept         = (state_q == ST_RUN) && evt_valid;
  assign flush_last     = (cnt_q == CNT_LAST);
  assign squash_slot1_o = (state_q == ST_RUN) && slot0_valid && (slot0_kind != CK_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      cnt_q            <= '0;
      kind_q           <= CK_NONE;
      target_q         <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      csr_excp_we_o    <= 1'b0;
      csr_ertn_we_o    <= 1'b0;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      kind_q           <= kind_n;
      target_q         <= target_n;
      flush_o          <= flush_n;
      redirect_valid_o <= redirect_n;
      csr_excp_we_o    <= excp_we_n;
      csr_ertn_we_o    <= ertn_we_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    kind_n   = kind_q;
    target_n = target_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          state_n  = ST_FLUSH;
          cnt_n    = '0;
          kind_n   = evt_kind;
          target_n = evt_target;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          state_n = (kind_q == CK_IDLE) ? ST_IDLE_WAIT : ST_REDIRECT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_REDIRECT:  state_n = ST_RUN;
      ST_IDLE_WAIT: if (int_pending_i) state_n = ST_REDIRECT;
      default:      state_n = ST_RUN;
    endcase
  end

  // Registered strobes are computed one cycle ahead from the transition being taken.
  always_comb begin
    flush_n    = 1'b0;
    redirect_n = 1'b0;
    excp_we_n  = 1'b0;
    ertn_we_n  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          flush_n   = 1'b1;
          excp_we_n = (evt_kind == CK_EXCP);
          ertn_we_n = (evt_kind == CK_ERTN);
        end
      end
      ST_FLUSH: begin
        if (flush_last) redirect_n = (kind_q != CK_IDLE);
        else            flush_n    = 1'b1;
      end
      ST_IDLE_WAIT: redirect_n = int_pending_i;
      default: ;
    endcase
  end

  assign stall_o       = (state_q != ST_RUN);
  assign idle_o        = (state_q == ST_IDLE_WAIT);
  assign redirect_pc_o = redirect_valid_o ? target_q : '0;

endmodule

// File: tb/tb_commit_flush_sequencer.sv
// Randomised scoreboard bench for commit_flush_sequencer against a cycle-timeline
// reference model built from the event acceptance and latency rules.
module tb_commit_flush_sequencer;
  import pipeline_defines::*;

  localparam int FC   = 2;
  localparam int AW   = 32;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slot0_valid = 1'b0, slot1_valid = 1'b0;
  commit_kind_e  slot0_kind = CK_NONE, slot1_kind = CK_NONE;
  logic [AW-1:0] slot0_pc = '0, slot1_pc = '0;
  logic          slot0_tlbr = 1'b0, slot1_tlbr = 1'b0;
  logic [AW-1:0] excp_entry_i = '0, tlbr_entry_i = '0, era_i = '0;
  logic          int_pending_i = 1'b0;
  logic          squash_slot1_o, flush_o, stall_o, redirect_valid_o;
  logic [AW-1:0] redirect_pc_o;
  logic          csr_excp_we_o, csr_ertn_we_o, idle_o;

  commit_flush_sequencer #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .slot0_valid(slot0_valid), .slot0_kind(slot0_kind), .slot0_pc(slot0_pc), .slot0_tlbr(slot0_tlbr),
    .slot1_valid(slot1_valid), .slot1_kind(slot1_kind), .slot1_pc(slot1_pc), .slot1_tlbr(slot1_tlbr),
    .excp_entry_i(excp_entry_i), .tlbr_entry_i(tlbr_entry_i), .era_i(era_i),
    .int_pending_i(int_pending_i),
    .squash_slot1_o(squash_slot1_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .csr_excp_we_o(csr_excp_we_o), .csr_ertn_we_o(csr_ertn_we_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [AW-1:0] pc; } redir_t;
  redir_t exp_q[$];

  bit exp_squash[MAXC], exp_flush[MAXC], exp_stall[MAXC];
  bit exp_idle[MAXC], exp_excp[MAXC], exp_ertn[MAXC];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            check_en = 1'b0;
  int            busy_until = 0;
  bit            idle_pending = 1'b0;
  int            idle_start = 0;
  logic [AW-1:0] idle_target = '0;
  logic [AW-1:0] nxt_excp = '0, nxt_tlbr = '0, nxt_era = '0;

  task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides acceptance for the current cycle and paints the
  // expected output timeline for the cycles that follow.
  task automatic modelStep();
    int c = cyc;
    bit free;
    bit have_evt;
    commit_kind_e k;
    logic [AW-1:0] pc, tgt;
    logic tl;
    free = !idle_pending && (c >= busy_until);
    exp_squash[c] = free && slot0_valid && (slot0_kind != CK_NONE);
    if (idle_pending && c >= idle_start) begin
      exp_idle[c]  = 1'b1;
      exp_stall[c] = 1'b1;
      if (int_pending_i && !rst) begin
        exp_q.push_back('{cyc: c + 1, pc: idle_target});
        exp_stall[c+1] = 1'b1;
        busy_until     = c + 2;
        idle_pending   = 1'b0;
      end
    end
    have_evt = 1'b0;
    k = CK_NONE; pc = '0; tl = 1'b0;
    if (slot0_valid && slot0_kind != CK_NONE) begin
      have_evt = 1'b1; k = slot0_kind; pc = slot0_pc; tl = slot0_tlbr;
    end else if (slot1_valid && slot1_kind != CK_NONE) begin
      have_evt = 1'b1; k = slot1_kind; pc = slot1_pc; tl = slot1_tlbr;
    end
    if (free && have_evt && !rst) begin
      if (k == CK_EXCP)      tgt = tl ? tlbr_entry_i : excp_entry_i;
      else if (k == CK_ERTN) tgt = era_i;
      else                   tgt = pc + 32'd4;
      for (int i = 1; i <= FC; i++) begin
        exp_flush[c+i] = 1'b1;
        exp_stall[c+i] = 1'b1;
      end
      exp_excp[c+1] = (k == CK_EXCP);
      exp_ertn[c+1] = (k == CK_ERTN);
      if (k == CK_IDLE) begin
        idle_pending = 1'b1;
        idle_start   = c + 1 + FC;
        idle_target  = tgt;
      end else begin
        exp_q.push_back('{cyc: c + 1 + FC, pc: tgt});
        exp_stall[c+1+FC] = 1'b1;
        busy_until        = c + 2 + FC;
      end
    end
    if (rst) begin
      for (int i = c + 1; i <= c + FC + 3 && i < MAXC; i++) begin
        exp_squash[i] = 0; exp_flush[i] = 0; exp_stall[i] = 0;
        exp_idle[i] = 0; exp_excp[i] = 0; exp_ertn[i] = 0;
      end
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > c) void'(exp_q.pop_back());
      idle_pending = 1'b0;
      busy_until   = c + 1;
    end
  endtask

  task automatic applyStimulus(input logic v0, input commit_kind_e k0, input logic [AW-1:0] pc0,
                               input logic tl0, input logic v1, input commit_kind_e k1,
                               input logic [AW-1:0] pc1, input logic tl1,
                               input logic intp, input logic r);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    slot0_valid = v0; slot0_kind = k0; slot0_pc = pc0; slot0_tlbr = tl0;
    slot1_valid = v1; slot1_kind = k1; slot1_pc = pc1; slot1_tlbr = tl1;
    excp_entry_i = nxt_excp; tlbr_entry_i = nxt_tlbr; era_i = nxt_era;
    int_pending_i = intp;
    modelStep();
  endtask

  task automatic idleCycles(input int n, input logic intp);
    for (int i = 0; i < n; i++)
      applyStimulus(0, CK_NONE, '0, 0, 0, CK_NONE, '0, 0, intp, 0);
  endtask

  // Monitor: compares registered outputs to the timeline and pops the scoreboard on redirects.
  initial begin
    bit expected_now;
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("squash_slot1", AW'(squash_slot1_o), AW'(exp_squash[cyc]));
        checkOutput("flush", AW'(flush_o), AW'(exp_flush[cyc]));
        checkOutput("stall", AW'(stall_o), AW'(exp_stall[cyc]));
        checkOutput("idle", AW'(idle_o), AW'(exp_idle[cyc]));
        checkOutput("csr_excp_we", AW'(csr_excp_we_o), AW'(exp_excp[cyc]));
        checkOutput("csr_ertn_we", AW'(csr_ertn_we_o), AW'(exp_ertn[cyc]));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checkOutput("redirect_missing", AW'(0), AW'(1));
          void'(exp_q.pop_front());
        end
        expected_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        checkOutput("redirect_valid", AW'(redirect_valid_o), AW'(expected_now));
        if (expected_now) begin
          if (redirect_valid_o) checkOutput("redirect_pc", redirect_pc_o, exp_q[0].pc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic v0, v1, t0, t1, ip, r;
    commit_kind_e k0, k1;

    for (int i = 0; i < 3; i++) applyStimulus(0, CK_NONE, '0, 0, 0, CK_NONE, '0, 0, 0, 1);
    check_en = 1'b1;
    idleCycles(2, 0);

    nxt_excp = 32'h1c008000; nxt_tlbr = 32'h1c00f000; nxt_era = 32'h1c000200;
    applyStimulus(1, CK_EXCP, 32'h1c000010, 0, 0, CK_NONE, '0, 0, 0, 0);
    idleCycles(FC + 3, 0);

    applyStimulus(1, CK_NONE, 32'h1c000020, 0, 1, CK_EXCP, 32'h1c000024, 1, 0, 0);
    idleCycles(FC + 3, 0);

    applyStimulus(1, CK_ERTN, 32'h1c000030, 0, 1, CK_REFETCH, 32'h1c000034, 0, 0, 0);
    idleCycles(FC + 3, 0);

    applyStimulus(1, CK_IDLE, 32'hfffffffc, 0, 0, CK_NONE, '0, 0, 0, 0);
    idleCycles(FC + 10, 0);
    idleCycles(1, 1);
    idleCycles(FC + 3, 0);

    applyStimulus(1, CK_EXCP, 32'h1c000040, 0, 0, CK_NONE, '0, 0, 0, 0);
    idleCycles(1, 0);
    applyStimulus(0, CK_NONE, '0, 0, 0, CK_NONE, '0, 0, 0, 1);
    idleCycles(FC + 4, 0);

    applyStimulus(1, CK_IDLE, 32'h1c000050, 0, 0, CK_NONE, '0, 0, 0, 0);
    idleCycles(FC + 4, 0);
    applyStimulus(0, CK_NONE, '0, 0, 0, CK_NONE, '0, 0, 1, 1);
    idleCycles(FC + 4, 0);

    for (int i = 0; i < 16; i++)
      applyStimulus(1, CK_REFETCH, 32'h1c000100 + 32'(4 * i), 0, 0, CK_NONE, '0, 0, 0, 0);
    idleCycles(FC + 3, 0);

    for (int i = 0; i < 2000; i++) begin
      nxt_excp = $urandom; nxt_tlbr = $urandom; nxt_era = $urandom;
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 1) != 0);
      k0 = commit_kind_e'(3'($urandom_range(0, 4)));
      k1 = commit_kind_e'(3'($urandom_range(0, 4)));
      t0 = $urandom_range(0, 1);
      t1 = $urandom_range(0, 1);
      ip = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 199) == 0);
      applyStimulus(v0, k0, $urandom, t0, v1, k1, $urandom, t1, ip, r);
    end

    idleCycles(FC + 3, 1);
    idleCycles(FC + 3, 0);
    @(negedge clk);
    @(posedge clk);
    checkOutput("scoreboard_empty", AW'(exp_q.size()), AW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
